// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - three-line edge-triggered interrupt front end with mask, enable and priority grant
// Optional IRQ_NESTING_EN lets a higher line preempt a running lower-priority handler.
module irq_controller #(
  parameter logic [31:0] VEC0 = 32'h0000_0100,
  parameter logic [31:0] VEC1 = 32'h0000_0200,
  parameter logic [31:0] VEC2 = 32'h0000_0300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic        irq_ack,
  input  logic        eret,
  input  logic        mask_we,
  input  logic [2:0]  mask_din,
  input  logic        ie_we,
  input  logic        ie_din,
  output logic        irq_req,
  output logic [1:0]  irq_id,
  output logic [31:0] irq_vector,
  output logic [2:0]  pending,
  output logic [2:0]  in_service
);

  logic [2:0] r_s1, r_s2, r_s3;
  logic [2:0] r_pending, r_in_service, r_mask;
  logic       r_ie;

  logic [2:0]  w_edge, w_gate, w_elig, w_ack_oh, w_eret_clr;
  logic        w_req;
  logic [1:0]  w_id;
  logic [31:0] w_vec;

  assign w_edge = r_s2 & ~r_s3;

`ifdef IRQ_NESTING_EN
  // a line may only preempt handlers of strictly lower index
  assign w_gate[0] = ~|r_in_service;
  assign w_gate[1] = ~|r_in_service[2:1];
  assign w_gate[2] = ~r_in_service[2];
`else
  assign w_gate = {3{~|r_in_service}};
`endif

  assign w_elig = r_pending & ~r_mask & {3{r_ie}} & w_gate;

  always_comb begin
    w_req = 1'b0;
    w_id  = 2'd0;
    w_vec = 32'h0;
    if (w_elig[2]) begin
      w_req = 1'b1;
      w_id  = 2'd2;
      w_vec = VEC2;
    end else if (w_elig[1]) begin
      w_req = 1'b1;
      w_id  = 2'd1;
      w_vec = VEC1;
    end else if (w_elig[0]) begin
      w_req = 1'b1;
      w_id  = 2'd0;
      w_vec = VEC0;
    end
  end

  always_comb begin
    w_ack_oh = 3'b000;
    if (irq_ack && w_req) begin
      w_ack_oh = 3'b001 << w_id;
    end
  end

  // eret retires the most recently entered (highest) handler
  always_comb begin
    w_eret_clr = 3'b000;
    if (eret) begin
      if (r_in_service[2])      w_eret_clr = 3'b100;
      else if (r_in_service[1]) w_eret_clr = 3'b010;
      else if (r_in_service[0]) w_eret_clr = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1         <= 3'b000;
      r_s2         <= 3'b000;
      r_s3         <= 3'b000;
      r_pending    <= 3'b000;
      r_in_service <= 3'b000;
      r_mask       <= 3'b000;
      r_ie         <= 1'b1;
    end else begin
      r_s1         <= irq_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      // a fresh edge on the line being acked wins over the clear
      r_pending    <= (r_pending & ~w_ack_oh) | w_edge;
      r_in_service <= (r_in_service & ~w_eret_clr) | w_ack_oh;
      if (mask_we) r_mask <= mask_din;
      if (ie_we)   r_ie   <= ie_din;
    end
  end

  assign irq_req    = w_req;
  assign irq_id     = w_id;
  assign irq_vector = w_vec;
  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller, directed scenarios plus random run against a model
// Build with IRQ_NESTING_EN defined to check the nesting variant.
`define TB_OBS {irq_req, irq_id, irq_vector, pending, in_service}
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = 3'b000;
  logic        irq_ack = 1'b0;
  logic        eret = 1'b0;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_din = 3'b000;
  logic        ie_we = 1'b0;
  logic        ie_din = 1'b1;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [31:0] irq_vector;
  logic [2:0]  pending;
  logic [2:0]  in_service;

  int checks = 0;
  int failures = 0;

  bit [2:0]  m_pend, m_svc, m_mask;
  bit        m_ie;
  bit [2:0]  m_hist [3];
  bit [31:0] m_vec_tab [3] = '{32'h100, 32'h200, 32'h300};

  irq_controller dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_ack(irq_ack), .eret(eret),
    .mask_we(mask_we), .mask_din(mask_din), .ie_we(ie_we), .ie_din(ie_din),
    .irq_req(irq_req), .irq_id(irq_id), .irq_vector(irq_vector),
    .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  function automatic bit m_gate(int i);
`ifdef IRQ_NESTING_EN
    for (int j = i; j < 3; j++) if (m_svc[j]) return 1'b0;
    return 1'b1;
`else
    return (m_svc == 3'b000);
`endif
  endfunction

  function automatic void m_outputs(output logic req, output logic [1:0] id, output logic [31:0] vec);
    req = 1'b0;
    id  = 2'd0;
    vec = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (m_pend[i] && !m_mask[i] && m_ie && m_gate(i)) begin
        req = 1'b1;
        id  = 2'(i);
        vec = m_vec_tab[i];
      end
    end
  endfunction

  // one rising edge: model consumes the inputs the DUT sampled, then wait for the falling edge
  task automatic tick();
    logic req;
    logic [1:0] id;
    logic [31:0] vec;
    bit [2:0] edges;
    int hi;
    @(posedge clk);
    m_outputs(req, id, vec);
    if (rst) begin
      m_pend = 0; m_svc = 0; m_mask = 0; m_ie = 1'b1;
      for (int k = 0; k < 3; k++) m_hist[k] = 3'b000;
    end else begin
      edges = m_hist[1] & ~m_hist[2];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = irq_in;
      if (eret) begin
        hi = -1;
        for (int i = 0; i < 3; i++) if (m_svc[i]) hi = i;
        if (hi >= 0) m_svc[hi] = 1'b0;
      end
      if (irq_ack && req) begin
        m_pend[id] = 1'b0;
        m_svc[id]  = 1'b1;
      end
      m_pend = m_pend | edges;
      if (mask_we) m_mask = mask_din;
      if (ie_we) m_ie = ie_din;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (`TB_OBS !== 41'h0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", `TB_OBS, 41'h0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    irq_in = 3'b010;
    for (int n = 1; n <= 2; n++) begin
      tick();
      checks++;
      if (irq_req !== 1'b0) begin
        failures++;
        $display("FAIL latency_early edge=%0d got=%b exp=0", n, irq_req);
      end
    end
    tick();
    checks++;
    if (`TB_OBS !== {1'b1, 2'd1, 32'h200, 3'b010, 3'b000}) begin
      failures++;
      $display("FAIL latency_req got=%h exp=%h", `TB_OBS, {1'b1, 2'd1, 32'h200, 3'b010, 3'b000});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if (`TB_OBS !== {1'b0, 2'd0, 32'h0, 3'b000, 3'b010}) begin
      failures++;
      $display("FAIL latency_ack got=%h exp=%h", `TB_OBS, {1'b0, 2'd0, 32'h0, 3'b000, 3'b010});
    end
    eret = 1'b1; tick(); eret = 1'b0;
    checks++;
    if (`TB_OBS !== 41'h0) begin
      failures++;
      $display("FAIL latency_eret_level_held got=%h exp=%h", `TB_OBS, 41'h0);
    end
    irq_in = 3'b000; tick(); tick();
  endtask

  task automatic test_priority();
    irq_in = 3'b101;
    tick(); tick(); tick();
    checks++;
    if (`TB_OBS !== {1'b1, 2'd2, 32'h300, 3'b101, 3'b000}) begin
      failures++;
      $display("FAIL prio_grant got=%h exp=%h", `TB_OBS, {1'b1, 2'd2, 32'h300, 3'b101, 3'b000});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 3'b000;
    checks++;
    if (`TB_OBS !== {1'b0, 2'd0, 32'h0, 3'b001, 3'b100}) begin
      failures++;
      $display("FAIL prio_ack got=%h exp=%h", `TB_OBS, {1'b0, 2'd0, 32'h0, 3'b001, 3'b100});
    end
    eret = 1'b1; tick(); eret = 1'b0;
    checks++;
    if (`TB_OBS !== {1'b1, 2'd0, 32'h100, 3'b001, 3'b000}) begin
      failures++;
      $display("FAIL prio_eret got=%h exp=%h", `TB_OBS, {1'b1, 2'd0, 32'h100, 3'b001, 3'b000});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    checks++;
    if (`TB_OBS !== 41'h0) begin
      failures++;
      $display("FAIL prio_done got=%h exp=%h", `TB_OBS, 41'h0);
    end
  endtask

  task automatic test_mask_ie();
    mask_we = 1'b1; mask_din = 3'b001; tick(); mask_we = 1'b0;
    irq_in = 3'b001;
    tick(); tick(); tick();
    irq_in = 3'b000;
    checks++;
    if (`TB_OBS !== {1'b0, 2'd0, 32'h0, 3'b001, 3'b000}) begin
      failures++;
      $display("FAIL mask_blocks got=%h exp=%h", `TB_OBS, {1'b0, 2'd0, 32'h0, 3'b001, 3'b000});
    end
    mask_we = 1'b1; mask_din = 3'b000; tick(); mask_we = 1'b0;
    checks++;
    if (`TB_OBS !== {1'b1, 2'd0, 32'h100, 3'b001, 3'b000}) begin
      failures++;
      $display("FAIL mask_clear got=%h exp=%h", `TB_OBS, {1'b1, 2'd0, 32'h100, 3'b001, 3'b000});
    end
    ie_we = 1'b1; ie_din = 1'b0; tick();
    checks++;
    if (irq_req !== 1'b0) begin
      failures++;
      $display("FAIL ie_off got=%b exp=0", irq_req);
    end
    ie_din = 1'b1; tick(); ie_we = 1'b0;
    checks++;
    if (irq_req !== 1'b1) begin
      failures++;
      $display("FAIL ie_on got=%b exp=1", irq_req);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_nesting();
    irq_in = 3'b001;
    tick(); tick(); tick();
    irq_in = 3'b000;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 3'b100;
    tick(); tick(); tick();
    irq_in = 3'b000;
`ifdef IRQ_NESTING_EN
    checks++;
    if (`TB_OBS !== {1'b1, 2'd2, 32'h300, 3'b100, 3'b001}) begin
      failures++;
      $display("FAIL nest_preempt got=%h exp=%h", `TB_OBS, {1'b1, 2'd2, 32'h300, 3'b100, 3'b001});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if (in_service !== 3'b101) begin
      failures++;
      $display("FAIL nest_ack got=%b exp=101", in_service);
    end
    eret = 1'b1; tick();
    checks++;
    if (in_service !== 3'b001) begin
      failures++;
      $display("FAIL nest_eret1 got=%b exp=001", in_service);
    end
    tick(); eret = 1'b0;
    checks++;
    if (`TB_OBS !== 41'h0) begin
      failures++;
      $display("FAIL nest_eret2 got=%h exp=%h", `TB_OBS, 41'h0);
    end
`else
    checks++;
    if (`TB_OBS !== {1'b0, 2'd0, 32'h0, 3'b100, 3'b001}) begin
      failures++;
      $display("FAIL nonest_blocked got=%h exp=%h", `TB_OBS, {1'b0, 2'd0, 32'h0, 3'b100, 3'b001});
    end
    eret = 1'b1; tick(); eret = 1'b0;
    checks++;
    if (`TB_OBS !== {1'b1, 2'd2, 32'h300, 3'b100, 3'b000}) begin
      failures++;
      $display("FAIL nonest_after_eret got=%h exp=%h", `TB_OBS, {1'b1, 2'd2, 32'h300, 3'b100, 3'b000});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
    checks++;
    if (`TB_OBS !== 41'h0) begin
      failures++;
      $display("FAIL nonest_done got=%h exp=%h", `TB_OBS, 41'h0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    irq_in = 3'b010; tick(); tick();
    irq_in = 3'b000; tick();
    checks++;
    if (`TB_OBS !== {1'b1, 2'd1, 32'h200, 3'b010, 3'b000}) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", `TB_OBS, {1'b1, 2'd1, 32'h200, 3'b010, 3'b000});
    end
    tick();
    irq_in = 3'b010; tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if (`TB_OBS !== {1'b0, 2'd0, 32'h0, 3'b010, 3'b010}) begin
      failures++;
      $display("FAIL b2b_edge_with_ack got=%h exp=%h", `TB_OBS, {1'b0, 2'd0, 32'h0, 3'b010, 3'b010});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++;
    if (`TB_OBS !== {1'b0, 2'd0, 32'h0, 3'b010, 3'b010}) begin
      failures++;
      $display("FAIL b2b_stray_ack got=%h exp=%h", `TB_OBS, {1'b0, 2'd0, 32'h0, 3'b010, 3'b010});
    end
    irq_in = 3'b000;
    eret = 1'b1; tick(); eret = 1'b0;
    checks++;
    if (`TB_OBS !== {1'b1, 2'd1, 32'h200, 3'b010, 3'b000}) begin
      failures++;
      $display("FAIL b2b_rerequest got=%h exp=%h", `TB_OBS, {1'b1, 2'd1, 32'h200, 3'b010, 3'b000});
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_reset_mid();
    irq_in = 3'b010; tick(); tick(); tick();
    irq_in = 3'b000;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 3'b111; tick(); tick(); tick();
    checks++;
    if ({pending, in_service} !== 6'b111_010) begin
      failures++;
      $display("FAIL rstmid_setup got=%b exp=111010", {pending, in_service});
    end
    rst = 1'b1; tick();
    checks++;
    if (`TB_OBS !== 41'h0) begin
      failures++;
      $display("FAIL rstmid_cleared got=%h exp=%h", `TB_OBS, 41'h0);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (irq_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_early got=%b exp=0", irq_req);
    end
    tick();
    checks++;
    if (`TB_OBS !== {1'b1, 2'd2, 32'h300, 3'b111, 3'b000}) begin
      failures++;
      $display("FAIL rstmid_fresh_edge got=%h exp=%h", `TB_OBS, {1'b1, 2'd2, 32'h300, 3'b111, 3'b000});
    end
    irq_in = 3'b000;
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_random();
    logic req;
    logic [1:0] id;
    logic [31:0] vec;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) irq_in = 3'($urandom);
      irq_ack  = ($urandom_range(9) < 3);
      eret     = ($urandom_range(9) < 2);
      mask_we  = ($urandom_range(19) == 0);
      mask_din = 3'($urandom);
      ie_we    = ($urandom_range(19) == 0);
      ie_din   = ($urandom_range(3) != 0);
      rst      = ($urandom_range(249) == 0);
      tick();
      m_outputs(req, id, vec);
      checks++;
      if (`TB_OBS !== {req, id, vec, m_pend, m_svc}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, `TB_OBS, {req, id, vec, m_pend, m_svc});
      end
    end
    irq_ack = 1'b0; eret = 1'b0; mask_we = 1'b0; ie_we = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_priority();
    test_mask_ie();
    test_nesting();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
